// File: rtl/nn_fixed_pkg.sv
// Shared Q8.24 fixed-point definitions for the training datapath.
package nn_fixed_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned FRAC_BITS = 24;

  localparam logic [WIDTH-1:0] ONE  = 32'h0100_0000;
  localparam logic [WIDTH-1:0] HALF = 32'h0080_0000;

  typedef enum logic [1:0] {
    StIdle,
    StMul1,
    StMul2,
    StDone
  } state_e;

endpackage

// File: rtl/mult.sv
// Signed fixed-point multiplier: full-width product, arithmetic shift by FRAC_BITS,
// low WIDTH bits kept (wraps on overflow).
module mult #(
  parameter int unsigned WIDTH     = nn_fixed_pkg::WIDTH,
  parameter int unsigned FRAC_BITS = nn_fixed_pkg::FRAC_BITS
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);

  logic signed [2*WIDTH-1:0] w_full;
  logic                      w_unused_bits;

  assign w_full = $signed(i_a) * $signed(i_b);
  // Bit slice at FRAC_BITS is the arithmetic shift right followed by truncation.
  assign o_p    = w_full[FRAC_BITS +: WIDTH];

  assign w_unused_bits = ^{w_full[2*WIDTH-1 -: WIDTH-FRAC_BITS], w_full[FRAC_BITS-1:0]};

endmodule

// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: delta = err * y * (1 - y), one shared multiplier, 3-cycle cadence.
// Optional SIGMOID_BP_CLAMP_EN clamps the captured activation into [0, ONE].
module sigmoid_backprop #(
  parameter int unsigned WIDTH     = nn_fixed_pkg::WIDTH,
  parameter int unsigned FRAC_BITS = nn_fixed_pkg::FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] err_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] delta_out,
  output logic             busy
);

  import nn_fixed_pkg::*;

  localparam logic [WIDTH-1:0] OneQ = WIDTH'(1) << FRAC_BITS;

  state_e           r_state;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_err;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_delta;
  logic             r_out_valid;

  logic             w_accept;
  logic [WIDTH-1:0] w_y_cap;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_prod;

  assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign delta_out = r_delta;
  assign busy      = (r_state != StIdle);

`ifdef SIGMOID_BP_CLAMP_EN
  always_comb begin
    w_y_cap = y_in;
    if ($signed(y_in) < 0) begin
      w_y_cap = '0;
    end else if ($signed(y_in) > $signed(OneQ)) begin
      w_y_cap = OneQ;
    end
  end
`else
  assign w_y_cap = y_in;
`endif

  // MUL1 forms y * (1 - y); MUL2 reuses the multiplier for t * err.
  assign w_a = (r_state == StMul1) ? r_y : r_t;
  assign w_b = (r_state == StMul1) ? (OneQ - r_y) : r_err;

  mult #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mult (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_y         <= '0;
      r_err       <= '0;
      r_t         <= '0;
      r_delta     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_y   <= w_y_cap;
        r_err <= err_in;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) r_state <= StMul1;
        end
        StMul1: begin
          r_t     <= w_prod;
          r_state <= StMul2;
        end
        StMul2: begin
          r_delta     <= w_prod;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_accept ? StMul1 : StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Scoreboard bench for sigmoid_backprop: driver pushes expected deltas, monitor pops on handshake.
module tb_sigmoid_backprop;

  localparam logic [31:0] ONE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] y_in = '0;
  logic [31:0] err_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] delta_out;
  logic        busy;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  sigmoid_backprop dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .err_in    (err_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .delta_out (delta_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint s;
    p = longint'($signed(a)) * longint'($signed(b));
    s = p >>> 24;
    return s[31:0];
  endfunction

  function automatic logic [31:0] ref_delta(input logic [31:0] y, input logic [31:0] err);
    logic [31:0] yc;
    yc = y;
`ifdef SIGMOID_BP_CLAMP_EN
    if ($signed(y) < 0) yc = '0;
    else if ($signed(y) > $signed(ONE)) yc = ONE;
`endif
    return fx_mul(fx_mul(yc, ONE - yc), err);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic send(input logic [31:0] y, input logic [31:0] err, input logic [31:0] exp);
    exp_t e;
    in_valid = 1'b1;
    y_in     = y;
    err_in   = err;
    for (int i = 0; ; i++) begin
      #1;
      if (in_ready) begin
        e.d = exp;
        e.c = cyc;
        q.push_back(e);
        break;
      end
      if (i >= 60) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        break;
      end
      step();
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      #1;
      if (q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  // Monitor: samples just after the falling edge, when handshake inputs are settled.
  initial begin
    bit   hold;
    exp_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (out_valid && !hold && q.size() > 0) chk("latency", cyc - q[0].c, 32'd3);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h, required no output", delta_out);
          end else begin
            e = q.pop_front();
            chk("delta", delta_out, e.d);
          end
        end
        hold = out_valid && !out_ready;
      end
    end
  end

  initial begin
    logic [31:0] y;
    logic [31:0] err;

    step();
    step();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_delta", delta_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    out_ready = 1'b1;
    send(32'h0080_0000, ONE, 32'h0040_0000);
    drain();
    send(32'h00C0_0000, 32'hFE00_0000, 32'hFFA0_0000);
    drain();
    send(32'h0000_0000, ONE, 32'h0);
    send(ONE, ONE, 32'h0);
`ifdef SIGMOID_BP_CLAMP_EN
    send(32'h0200_0000, ONE, 32'h0);
`else
    send(32'h0200_0000, ONE, 32'hFE00_0000);
`endif
    drain();

    // Stall in DONE, then hand off with a same-cycle accept.
    step();
    send(32'h00C0_0000, 32'hFE00_0000, 32'hFFA0_0000);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      if (out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_delta", delta_out, 32'hFFA0_0000);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      #1;
    end
    step();
    out_ready = 1'b1;
    send(32'h0080_0000, ONE, 32'h0040_0000);
    drain();

    // Reset while in MUL2 aborts the sample.
    step();
    send(32'h00C0_0000, ONE, 32'h0030_0000);
    step();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_delta", delta_out, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    q.delete();
    step();
    rst = 1'b0;
    step();
    send(32'h0080_0000, ONE, 32'h0040_0000);
    drain();

    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      y   = ($urandom_range(3) == 0) ? $urandom : $urandom_range(ONE);
      err = $urandom;
      send(y, err, ref_delta(y, err));
      if ($urandom_range(3) == 0) step();
    end
    drain();
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigmoid_backprop.md
Name: sigmoid_backprop

Overview:
- Backward-pass partner of the forward sigmoid activation. Consumes a stored activation y = sigmoid(x) and an upstream gradient err. Produces the local gradient delta = err * y * (1 - y).
- Signed Q8.24 fixed point throughout (1.0 = 0x01000000), the same format as the forward path.
- Sits between the output-error stage and the weight-update stage of the training datapath.
- Time-shares one fixed-point multiplier under a small FSM, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, data word width in bits.
- FRAC_BITS, 24, number of fractional bits; ONE = 1 << FRAC_BITS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  y_in/err_in are valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- y_in  in  WIDTH  stored sigmoid activation, Q8.24 signed.
- err_in  in  WIDTH  upstream gradient, Q8.24 signed.
- out_valid  out  1  delta_out is valid; held until accepted.
- out_ready  in  1  downstream accepts delta_out.
- delta_out  out  WIDTH  local gradient, Q8.24 signed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE;
  - out_valid = 0, delta_out = 0, busy = 0;
  - internal y/err/t registers = 0.
- Reset mid-operation discards the in-flight sample with no output.
- States and transitions:
  - IDLE → MUL1 on accept.
  - MUL1 → MUL2 unconditionally.
  - MUL2 → DONE unconditionally.
  - DONE → IDLE on out_valid && out_ready with no new accept.
  - DONE → MUL1 on out_valid && out_ready with a simultaneous accept.
- Ready and accept:
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - Accept = in_valid && in_ready; y_in and err_in are registered on the accept edge.
- MUL1: register t = y_r * (ONE - y_r).
- MUL2: register delta = t * err_r. out_valid rises after this edge.
- Latency: out_valid is high 2 cycles after the accept edge. Maximum throughput is one sample per 3 cycles.
- DONE:
  - out_valid = 1; delta_out is stable while out_valid && !out_ready.
  - out_valid drops on the accepting edge unless a back-to-back accept occurred. In that case it drops and then rises again 2 cycles later.
- Multiply rule (both steps):
  - full 2*WIDTH signed product;
  - arithmetic shift right by FRAC_BITS (truncates toward -inf);
  - keep the low WIDTH bits.
- ONE - y_r is computed in WIDTH bits with two's-complement wrap.
- in_valid while not ready: ignored; the operands are not captured.
- busy = (state != IDLE).

Optional Feature:
- Macro: SIGMOID_BP_CLAMP_EN.
- Defined:
  - y_in < 0 is registered as 0.
  - y_in > ONE is registered as ONE.
  - Result: delta is 0 for any out-of-range activation.
- Undefined: y_in is registered raw and the arithmetic wraps as specified.

Decomposition:
- Shared package (nn_fixed_pkg):
  - WIDTH, FRAC_BITS;
  - Q8.24 constants ONE (0x01000000) and HALF (0x00800000);
  - FSM state enum (IDLE, MUL1, MUL2, DONE).
- One sub-module: the existing fixed-point multiplier mult, instantiated once. Its operands are muxed by state.

Test Plan:
- y=0x00800000, err=0x01000000, out_ready=1 → t=0x00400000; delta_out=0x00400000; out_valid high 2 cycles after accept.
- y=0x00C00000, err=0xFE000000 → delta_out=0xFFA00000 (-0.375).
- y=0x00000000 and y=0x01000000, each with err=0x01000000 → delta_out=0 in both cases.
- y=0x02000000, err=0x01000000 → delta_out=0 with SIGMOID_BP_CLAMP_EN; 0xFE000000 without.
- out_ready low for 5 cycles in DONE → delta_out stable and in_ready=0 throughout. Then raise out_ready with in_valid=1 → same-cycle handoff, second result 2 cycles later.
- Assert rst during MUL2 → out_valid=0, delta_out=0, busy=0 immediately; no output appears for the aborted sample; the next accept completes normally.
